// File: rtl/data_sram_resp.sv
// -----------------------------------------------------------------------------
// data_sram_resp
//
// Data-side SRAM responder with a small memory-mapped configuration register
// block. A single access port serves both a word-addressed RAM and the
// confreg region. Reads have a fixed one-cycle latency and never stall.
// Writes merge per byte lane.
//
// Address map (byte addresses, bits [1:0] ignored everywhere):
//   addr[31:16] == CONF_BASE[31:16]  -> confreg region, offset addr[15:0]
//       0xF000  LED      rw  (bits 15:0, byte lanes 0-1 only)
//       0xF010  SWITCH   ro  ({24'b0, synchronized switch})
//       0xF020  TIMER    rw  (free-running counter, optional)
//       0xF030  SCRATCH  rw  (32-bit)
//       other   reads 0, writes ignored
//   otherwise                        -> RAM word addr[ADDR_W+1:2]
//                                       (upper bits ignored, so the RAM aliases)
//
// Optional feature:
//   CONFREG_TIMER_EN  when defined, TIMER counts up every cycle and accepts
//                     writes (write wins over increment). When undefined,
//                     there is no counter: TIMER reads 0 and writes are dropped.
//
// Parameters:
//   ADDR_W     RAM word-address width (2^ADDR_W 32-bit words)
//   CONF_BASE  confreg region base; only the upper 16 bits are decoded
//
// Ports:
//   clk              in   single clock, all state on the rising edge
//   resetn           in   asynchronous active-low reset
//   data_sram_en     in   access request this cycle
//   data_sram_we     in   byte write strobes (nonzero = write, zero = read)
//   data_sram_addr   in   byte address
//   data_sram_wdata  in   write data, byte lanes per strobe
//   data_sram_rdata  out  registered read data, valid one cycle after a read
//   led              out  LED register contents
//   switch           in   asynchronous switch inputs
// -----------------------------------------------------------------------------
module data_sram_resp #(
    parameter int unsigned ADDR_W    = 10,
    parameter logic [31:0] CONF_BASE = 32'hBFAF_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch
);

    localparam int unsigned DEPTH       = 1 << ADDR_W;
    localparam logic [15:0] OFF_LED     = 16'hF000;
    localparam logic [15:0] OFF_SWITCH  = 16'hF010;
    localparam logic [15:0] OFF_TIMER   = 16'hF020;
    localparam logic [15:0] OFF_SCRATCH = 16'hF030;

    // -------------------------------------------------------------------------
    // Byte-lane merge shared by every read-write confreg.
    // -------------------------------------------------------------------------
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strobe
    );
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strobe[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Request decode (stage p0: the cycle the access is presented)
    // -------------------------------------------------------------------------
    logic              is_conf_p0;
    logic [ADDR_W-1:0] word_idx_p0;
    logic              access_p0;
    logic              wr_p0;
    logic              rd_p0;
    logic              sel_led_p0;
    logic              sel_switch_p0;
    logic              sel_timer_p0;
    logic              sel_scratch_p0;
    logic              unused_addr_lsb;

    assign is_conf_p0  = (data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign word_idx_p0 = data_sram_addr[ADDR_W+1:2];

    // Requests are dropped while reset is held, including by the RAM write
    // port, which has no reset of its own.
    assign access_p0 = data_sram_en & resetn;
    assign wr_p0     = access_p0 & (|data_sram_we);
    assign rd_p0     = access_p0 & ~(|data_sram_we);

    // Offsets are word-granular; the byte-offset bits never take part.
    assign sel_led_p0     = is_conf_p0 & (data_sram_addr[15:2] == OFF_LED[15:2]);
    assign sel_switch_p0  = is_conf_p0 & (data_sram_addr[15:2] == OFF_SWITCH[15:2]);
    assign sel_timer_p0   = is_conf_p0 & (data_sram_addr[15:2] == OFF_TIMER[15:2]);
    assign sel_scratch_p0 = is_conf_p0 & (data_sram_addr[15:2] == OFF_SCRATCH[15:2]);

    assign unused_addr_lsb = ^data_sram_addr[1:0];

    // -------------------------------------------------------------------------
    // RAM array. Deliberately not reset so contents survive a reset pulse;
    // per-lane write enables keep it mappable onto byte-write block RAM.
    // -------------------------------------------------------------------------
    logic [31:0] mem [DEPTH];
    logic        ram_wr_p0;

    assign ram_wr_p0 = wr_p0 & ~is_conf_p0;

    always_ff @(posedge clk) begin
        if (ram_wr_p0) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[word_idx_p0][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Switch synchronizer: two flops before the value is ever observed.
    // -------------------------------------------------------------------------
    logic [7:0] switch_meta;
    logic [7:0] switch_sync;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            switch_meta <= '0;
            switch_sync <= '0;
        end else begin
            switch_meta <= switch;
            switch_sync <= switch_meta;
        end
    end

    // -------------------------------------------------------------------------
    // LED and SCRATCH registers
    // -------------------------------------------------------------------------
    logic [31:0] scratch;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led     <= '0;
            scratch <= '0;
        end else begin
            if (wr_p0 && sel_led_p0) begin
                // Only lanes 0-1 exist in the LED register.
                if (data_sram_we[0]) led[7:0]  <= data_sram_wdata[7:0];
                if (data_sram_we[1]) led[15:8] <= data_sram_wdata[15:8];
            end
            if (wr_p0 && sel_scratch_p0) begin
                scratch <= merge_bytes(scratch, data_sram_wdata, data_sram_we);
            end
        end
    end

    // -------------------------------------------------------------------------
    // TIMER
    // -------------------------------------------------------------------------
    logic [31:0] timer;

`ifdef CONFREG_TIMER_EN
    // A write replaces this cycle's increment; counting resumes from the
    // written value on the following cycle. Wraps naturally at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer <= '0;
        end else if (wr_p0 && sel_timer_p0) begin
            timer <= merge_bytes(timer, data_sram_wdata, data_sram_we);
        end else begin
            timer <= timer + 32'd1;
        end
    end
`else
    // No counter in this build: the offset stays decoded but reads as zero.
    assign timer = '0;
`endif

    // -------------------------------------------------------------------------
    // Read select. Everything here reflects state as it stands in the
    // request cycle, so TIMER returns its current value and a RAM read right
    // after a write to the same word sees the committed data.
    // -------------------------------------------------------------------------
    logic [31:0] rd_val_p0;

    always_comb begin
        rd_val_p0 = '0;
        if (!is_conf_p0) begin
            rd_val_p0 = mem[word_idx_p0];
        end else if (sel_led_p0) begin
            rd_val_p0 = {16'h0000, led};
        end else if (sel_switch_p0) begin
            rd_val_p0 = {24'h000000, switch_sync};
        end else if (sel_timer_p0) begin
            rd_val_p0 = timer;
        end else if (sel_scratch_p0) begin
            rd_val_p0 = scratch;
        end
    end

    // -------------------------------------------------------------------------
    // Response register (stage p1). Updates only on a read; holds across
    // idle and write cycles. Reset discards any read in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= '0;
        end else if (rd_p0) begin
            data_sram_rdata <= rd_val_p0;
        end
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_data_sram_resp
//
// Self-checking bench for data_sram_resp. A behavioural model of the address
// map (RAM as an array, confregs as plain variables) predicts rdata and led
// every cycle; directed sequences pin the model with literal expectations,
// followed by a randomized phase with occasional reset pulses.
// Define CONFREG_TIMER_EN for both bench and design to exercise the timer.
// -----------------------------------------------------------------------------
module tb_data_sram_resp;

    localparam int          ADDR_W    = 10;
    localparam logic [31:0] CONF_BASE = 32'hBFAF_0000;
    localparam int          DEPTH     = 1 << ADDR_W;
    localparam int          POOL      = 16;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        en     = 1'b0;
    logic [3:0]  we     = 4'h0;
    logic [31:0] addr   = 32'h0;
    logic [31:0] wdata  = 32'h0;
    logic [7:0]  sw     = 8'h00;
    logic [31:0] rdata;
    logic [15:0] led;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_on   = 1'b0;

    data_sram_resp #(
        .ADDR_W   (ADDR_W),
        .CONF_BASE(CONF_BASE)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .data_sram_en   (en),
        .data_sram_we   (we),
        .data_sram_addr (addr),
        .data_sram_wdata(wdata),
        .data_sram_rdata(rdata),
        .led            (led),
        .switch         (sw)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [31:0] m_ram [DEPTH];
    logic [15:0] m_led;
    logic [31:0] m_scratch;
    logic [31:0] m_timer;
    logic [31:0] m_rdata;
    logic [7:0]  m_sw_hist [2];   // [0] = sampled last edge, [1] = two edges ago
    logic [31:0] m_tmp;
    logic [31:0] m_timer_next;

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = new_v[8*b +: 8];
        return r;
    endfunction

    function automatic bit in_conf(input logic [31:0] a);
        return (a >> 16) == (CONF_BASE >> 16);
    endfunction

    function automatic int ram_index(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [15:0] conf_off(input logic [31:0] a);
        return a[15:0] & 16'hFFFC;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (!in_conf(a)) return m_ram[ram_index(a)];
        case (conf_off(a))
            16'hF000: return {16'h0, m_led};
            16'hF010: return {24'h0, m_sw_hist[1]};
            16'hF020: return m_timer;
            16'hF030: return m_scratch;
            default:  return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_led       = '0;
            m_scratch   = '0;
            m_timer     = '0;
            m_rdata     = '0;
            m_sw_hist[0] = '0;
            m_sw_hist[1] = '0;
        end else begin
`ifdef CONFREG_TIMER_EN
            m_timer_next = m_timer + 32'd1;
`else
            m_timer_next = 32'd0;
`endif
            if (en && we == 4'h0) m_rdata = model_read(addr);
            if (en && we != 4'h0) begin
                if (!in_conf(addr)) begin
                    m_ram[ram_index(addr)] = lanes(m_ram[ram_index(addr)], wdata, we);
                end else begin
                    case (conf_off(addr))
                        16'hF000: begin
                            m_tmp = lanes({16'h0, m_led}, wdata, we & 4'b0011);
                            m_led = m_tmp[15:0];
                        end
`ifdef CONFREG_TIMER_EN
                        16'hF020: m_timer_next = lanes(m_timer, wdata, we);
`endif
                        16'hF030: m_scratch = lanes(m_scratch, wdata, we);
                        default: ;
                    endcase
                end
            end
            m_timer      = m_timer_next;
            m_sw_hist[1] = m_sw_hist[0];
            m_sw_hist[0] = sw;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("cycle_rdata", rdata, m_rdata);
            check("cycle_led", {16'h0, led}, {16'h0, m_led});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        en = 1'b0; we = 4'h0; addr = $urandom; wdata = $urandom;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] rand_ram_addr();
        logic [31:0] a;
        a = $urandom;
        a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, POOL-1));
        if (in_conf(a)) a[31] = ~a[31];
        return a;
    endfunction

    function automatic logic [31:0] rand_conf_addr();
        logic [15:0] offs [7];
        logic [31:0] a;
        offs = '{16'hF000, 16'hF010, 16'hF020, 16'hF030, 16'hF004, 16'hF040, 16'h0000};
        a = {CONF_BASE[31:16], offs[$urandom_range(0, 6)]};
        a[1:0] = 2'($urandom);
        return a;
    endfunction

    logic [31:0] held;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        cmp_on = 1'b1;
        check("reset_rdata", rdata, 32'h0);
        check("reset_led", {16'h0, led}, 32'h0);
        resetn = 1'b1;
        idle(1);

        // Full-word write then read
        access(4'hF, 32'h0000_0010, 32'h1234_5678);
        access(4'h0, 32'h0000_0010, 32'h0);
        check("ram_full_word", rdata, 32'h1234_5678);

        // Byte-lane merge on RAM
        access(4'b0010, 32'h0000_0010, 32'h0000_AB00);
        access(4'h0, 32'h0000_0010, 32'h0);
        check("ram_lane_merge", rdata, 32'h1234_AB78);

        // Aliasing: upper address bits ignored for RAM
        access(4'hF, 32'h8000_1010, 32'h5A5A_0F0F);
        access(4'h0, 32'h0000_0010, 32'h0);
        check("ram_alias", rdata, 32'h5A5A_0F0F);

        // Hold across idle and write cycles
        held = rdata;
        idle(2);
        check("hold_idle", rdata, held);
        access(4'hF, 32'h0000_0014, 32'h7777_7777);
        check("hold_write", rdata, held);

        // LED
        access(4'hF, 32'hBFAF_F000, 32'hFFFF_00A5);
        check("led_value", {16'h0, led}, 32'h0000_00A5);
        access(4'h0, 32'hBFAF_F000, 32'h0);
        check("led_read", rdata, 32'h0000_00A5);

        // SWITCH through synchronizer, write ignored
        sw = 8'h3C;
        idle(3);
        access(4'h0, 32'hBFAF_F010, 32'h0);
        check("switch_read", rdata, 32'h0000_003C);
        access(4'hF, 32'hBFAF_F010, 32'hFFFF_FFFF);
        access(4'h0, 32'hBFAF_F010, 32'h0);
        check("switch_ro", rdata, 32'h0000_003C);

        // Unmapped offset reads 0, write ignored
        access(4'hF, 32'hBFAF_F040, 32'hDEAD_BEEF);
        access(4'h0, 32'hBFAF_F040, 32'h0);
        check("unmapped", rdata, 32'h0);

        // SCRATCH byte merge
        access(4'hF, 32'hBFAF_F030, 32'h1122_3344);
        access(4'b1001, 32'hBFAF_F030, 32'hAABB_CCDD);
        access(4'h0, 32'hBFAF_F033, 32'h0);
        check("scratch_merge", rdata, 32'hAA22_33DD);

        // TIMER
        access(4'hF, 32'hBFAF_F020, 32'hFFFF_FFFE);
        access(4'h0, 32'hBFAF_F020, 32'h0);
`ifdef CONFREG_TIMER_EN
        check("timer_written", rdata, 32'hFFFF_FFFE);
        access(4'h0, 32'hBFAF_F020, 32'h0);
        check("timer_inc", rdata, 32'hFFFF_FFFF);
        access(4'h0, 32'hBFAF_F020, 32'h0);
        check("timer_wrap", rdata, 32'h0000_0000);
`else
        check("timer_absent", rdata, 32'h0);
`endif

        // Reset during a read in flight; RAM survives
        access(4'hF, 32'h0000_0020, 32'hCAFE_F00D);
        access(4'h0, 32'hBFAF_F000, 32'h0);
        en = 1'b1; we = 4'h0; addr = 32'h0000_0020; resetn = 1'b0;
        @(posedge clk); #1;
        en = 1'b0;
        check("rst_discard", rdata, 32'h0);
        check("rst_led", {16'h0, led}, 32'h0);
        idle(1);
        resetn = 1'b1;
        idle(2);
        check("rst_hold_zero", rdata, 32'h0);
        access(4'h0, 32'h0000_0020, 32'h0);
        check("ram_survives_reset", rdata, 32'hCAFE_F00D);

        // Prefill the random pool so every RAM read hits a known word
        for (int i = 0; i < POOL; i++) access(4'hF, 32'(i * 4), $urandom);

        // Randomized traffic
        for (int it = 0; it < 3000; it++) begin
            en    = ($urandom_range(0, 3) != 0);
            we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            addr  = ($urandom_range(0, 9) < 3) ? rand_conf_addr() : rand_ram_addr();
            wdata = $urandom;
            if ($urandom_range(0, 19) == 0) sw = 8'($urandom);
            if (it % 700 == 350) resetn = 1'b0;
            if (it % 700 == 352) resetn = 1'b1;
            @(posedge clk); #1;
        end
        en = 1'b0;
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
